wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max stb-without-ack cycles before abort (range 1..1023).
REQ-002 clk_i  in  1  system clock; all logic on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 mN_cyc_i (N=0,1)  in  1  master N bus request / cycle valid; m0 = CPU load/store port, m1 = DMA port.
REQ-005 mN_stb_i  in  1  master N strobe.
REQ-006 mN_we_i  in  1  master N write enable.
REQ-007 mN_sel_i  in  4  master N byte selects.
REQ-008 mN_adr_i  in  18  master N address; [17:16] selects peripheral, [15:0] offset.
REQ-009 mN_dat_i  in  32  master N write data.
REQ-010 mN_dat_o  out  32  read data to master N.
REQ-011 mN_ack_o  out  1  transfer acknowledge to master N.
REQ-012 mN_err_o  out  1  timeout abort to master N.
REQ-013 s_cyc_o / s_stb_o / s_we_o  out  1 each  shared-port cycle, strobe, write enable.
REQ-014 s_sel_o  out  4;  s_adr_o  out  18;  s_dat_o  out  32  shared-port selects, address, write data.
REQ-015 s_dat_i  in  32;  s_ack_i  in  1  shared-port read data and acknowledge.
REQ-016 grant_o  out  2  one-hot current owner (bit N = master N); 00 when idle.
REQ-017 timeout_o  out  1  one-cycle pulse on any timeout abort.

Function
REQ-018 FSM states IDLE, OWN0, OWN1; state and last_grant (1 bit) registered.
REQ-019 IDLE: no request -> IDLE; only mN_cyc_i -> OWNN; both -> OWN of master != last_grant (round-robin).
REQ-020 Grant latency: exactly one cycle from mN_cyc_i rising in IDLE to OWNN; last_grant <= N on entry.
REQ-021 OWNN: s_cyc_o = mN_cyc_i, s_stb_o = mN_stb_i; s_we/sel/adr/dat_o = master N's inputs, combinational pass-through.
REQ-022 OWNN: mN_ack_o = s_ack_i, mN_dat_o = s_dat_i; other master's ack/err = 0, dat_o = 0.
REQ-023 IDLE: all s_* outputs, all mN_ack_o/mN_err_o/mN_dat_o = 0.
REQ-024 Ownership held until owner drops mN_cyc_i (sampled at clock edge) -> IDLE; multi-beat bursts under one cyc never interrupted by the other master.
REQ-025 One mandatory IDLE cycle between consecutive grants; no direct OWN0<->OWN1 transition.
REQ-026 Owner dropping cyc in same cycle as s_ack_i: ack still routed that cycle; next state IDLE.
REQ-027 Timeout counter, 10 bits: cleared on entry to OWNN, on s_ack_i, and whenever owner's stb is low; increments each OWNN cycle with stb=1 and s_ack_i=0.
REQ-028 Counter == TIMEOUT_CYCLES-1 and increment condition true: mN_err_o = 1 and timeout_o = 1 that cycle, s_cyc_o/s_stb_o forced 0 that cycle, next state IDLE.
REQ-029 s_ack_i in the same cycle as timeout: ack wins, no err, counter cleared.
REQ-030 After timeout abort, master N must drop cyc; re-grant only via normal IDLE arbitration.
REQ-031 s_ack_i while IDLE ignored; never forwarded to either master.
REQ-032 grant_o = one-hot of state (OWN0 -> 01, OWN1 -> 10, IDLE -> 00).

Reset
REQ-033 rst_i=1 at clock edge: state <= IDLE, last_grant <= 1 (m0 wins first contention), counter <= 0.
REQ-034 Reset mid-transfer: next cycle all outputs 0, no err pulse generated; reset dominates all other conditions.

Verification
REQ-035 Single request: m0 cyc/stb, adr=0x1_0004, s_ack_i on 3rd owned cycle -> grant_o=01 one cycle after cyc, s_adr_o=0x10004, m0_ack_o=1 only that cycle, m1_ack_o=0.
REQ-036 Contention: m0,m1 cyc rise same cycle after reset -> OWN0 first; after m0 drops cyc, 1 IDLE cycle, then grant_o=10; repeat both -> alternates m0,m1,m0.
REQ-037 Burst lock: m1 owns, 4 back-to-back acked beats with m0 requesting throughout -> grant_o stays 10 for all 4 beats; m0 granted only after m1 drops cyc plus 1 IDLE cycle.
REQ-038 Timeout: TIMEOUT_CYCLES=8, m0 stb held, s_ack_i=0 -> m0_err_o and timeout_o high exactly on 8th stb cycle, s_cyc_o=0 that cycle, grant_o=00 next; ack on 8th cycle instead -> ack, no err.
REQ-039 Reset mid-transfer: rst_i high during OWN1 with stb high -> next cycle all s_* and grant_o = 0, no err; after release with both requesting, m0 granted.
REQ-040 Stray ack: s_ack_i=1 while IDLE -> m0_ack_o=m1_ack_o=0, state unchanged.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant of a shared slave port to the CPU (m0) and DMA (m1),
// with bus locking for the whole cyc, a mandatory idle cycle between owners, and a stalled-strobe timeout abort.
module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [17:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [17:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [17:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_grant_q;
    logic [9:0]  tmo_cnt_q;
    logic [1:0]  grant_q;

    logic        own0;
    logic        own1;
    logic        own_cyc;
    logic        own_stb;
    logic        cnt_inc;
    logic        tmo;

    always_comb begin
        own0    = (state_q == OWN0);
        own1    = (state_q == OWN1);
        own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
        own_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
        cnt_inc = own_stb & ~s_ack_i;
        tmo     = cnt_inc & (tmo_cnt_q == TMO_LAST);
    end

    // Shared port follows the owner combinationally; an aborting cycle withdraws cyc/stb.
    assign s_cyc_o   = own_cyc & ~tmo;
    assign s_stb_o   = own_stb & ~tmo;
    assign s_we_o    = (own0 & m0_we_i) | (own1 & m1_we_i);
    assign s_sel_o   = ({4{own0}} & m0_sel_i) | ({4{own1}} & m1_sel_i);
    assign s_adr_o   = ({18{own0}} & m0_adr_i) | ({18{own1}} & m1_adr_i);
    assign s_dat_o   = ({32{own0}} & m0_dat_i) | ({32{own1}} & m1_dat_i);

    assign m0_ack_o  = own0 & s_ack_i;
    assign m1_ack_o  = own1 & s_ack_i;
    assign m0_dat_o  = {32{own0}} & s_dat_i;
    assign m1_dat_o  = {32{own1}} & s_dat_i;
    assign m0_err_o  = own0 & tmo & ~rst_i;
    assign m1_err_o  = own1 & tmo & ~rst_i;
    assign timeout_o = tmo & ~rst_i;
    assign grant_o   = grant_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            tmo_cnt_q    <= '0;
            grant_q      <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tmo_cnt_q <= '0;
                    // On contention the master that did not own last time wins.
                    if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
                        state_q      <= OWN0;
                        last_grant_q <= 1'b0;
                        grant_q      <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state_q      <= OWN1;
                        last_grant_q <= 1'b1;
                        grant_q      <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_cyc || tmo) begin
                        state_q   <= IDLE;
                        grant_q   <= 2'b00;
                        tmo_cnt_q <= '0;
                    end else if (cnt_inc) begin
                        tmo_cnt_q <= tmo_cnt_q + 10'd1;
                    end else begin
                        tmo_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    grant_q   <= 2'b00;
                    tmo_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule
